fpu_arbiter: RTL and testbench

//  Shares one FPU (ope/in1/in2 valid-ready in, data valid-ready out) among N_REQ cpu2 cores.
//  - Round-robin request arbitration.
//  - Registered issue stage toward the FPU.
//  - In-order tag FIFO that routes each FPU result back to its issuing core.
//  - Sits between the cores' f_* ports and the single FPU instance.

---
 rtl/fpu_arbiter.sv | 153 +++++++++++++++
 tb/tb_fpu_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// Shares one FPU among N_REQ requesters: round-robin accept, one registered issue stage,
// and an in-order tag FIFO that steers each FPU result back to the core that issued it.
module fpu_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_REQ-1:0]    req_ope,
  input  logic [32*N_REQ-1:0]   req_in1,
  input  logic [32*N_REQ-1:0]   req_in2,
  input  logic [N_REQ-1:0]      req_vld,
  output logic [N_REQ-1:0]      req_rdy,
  output logic [31:0]           rsp_data,
  output logic [N_REQ-1:0]      rsp_vld,
  input  logic [N_REQ-1:0]      rsp_rdy,
  output logic [3:0]            f_ope_data,
  output logic [31:0]           f_in1_data,
  output logic [31:0]           f_in2_data,
  output logic                  f_in_vld,
  input  logic                  f_in_rdy,
  input  logic [31:0]           f_out_data,
  input  logic                  f_out_vld,
  output logic                  f_out_rdy,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam int unsigned PW = $clog2(MAX_OUT);
  localparam int unsigned MaxOutInt = MAX_OUT;
  localparam logic [PW:0] MaxCnt = MaxOutInt[PW:0];

  typedef logic [1:0] id_t;

  logic [3:0]    ope_q;
  logic [31:0]   in1_q, in2_q;
  logic          vld_q;
  id_t           ptr_q;
  id_t           tags_q [MAX_OUT];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          err_q;

  logic          empty, can_acc, found, accept, issue, pop, head_rdy;
  id_t           winner, head;
  logic [3:0]    sel_ope;
  logic [31:0]   sel_in1, sel_in2;

  assign empty   = (cnt_q == '0);
  assign head    = tags_q[rd_q];
  assign can_acc = (!vld_q || f_in_rdy) && (cnt_q < MaxCnt);
  assign accept  = found && can_acc;
  assign issue   = vld_q && f_in_rdy;

  // Round-robin scan: indices above the last winner first, then wrap to 0..ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_vld[i] && (i > int'(ptr_q))) begin
        found  = 1'b1;
        winner = id_t'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_vld[i] && (i <= int'(ptr_q))) begin
        found  = 1'b1;
        winner = id_t'(i);
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    sel_ope = '0;
    sel_in1 = '0;
    sel_in2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == id_t'(i)) begin
        req_rdy[i] = found && can_acc;
        sel_ope    = req_ope[4*i +: 4];
        sel_in1    = req_in1[32*i +: 32];
        sel_in2    = req_in2[32*i +: 32];
      end
    end
  end

  always_comb begin
    rsp_vld  = '0;
    head_rdy = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (head == id_t'(i)) begin
        head_rdy   = rsp_rdy[i];
        rsp_vld[i] = f_out_vld && !empty;
      end
    end
  end

  assign f_out_rdy = !empty && head_rdy;
  assign pop       = f_out_vld && f_out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      ope_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      vld_q <= 1'b0;
      ptr_q <= id_t'(N_REQ - 1);
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        ope_q <= sel_ope;
        in1_q <= sel_in1;
        in2_q <= sel_in2;
        vld_q <= 1'b1;
        ptr_q <= winner;
        wr_q  <= wr_q + 1'b1;
      end else if (issue) begin
        vld_q <= 1'b0;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (accept && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!accept && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (f_out_vld && empty) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      tags_q[wr_q] <= winner;
    end
  end

  assign f_ope_data   = ope_q;
  assign f_in1_data   = in1_q;
  assign f_in2_data   = in2_q;
  assign f_in_vld     = vld_q;
  assign rsp_data     = f_out_data;
  assign busy         = !empty;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomized bench for fpu_arbiter: requester, FPU and consumer agents plus a queue-based
// reference model of the arbiter's rules, checked every cycle on the falling edge.
module tb_fpu_arbiter;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned MAX_OUT = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*N_REQ-1:0]  req_ope;
  logic [32*N_REQ-1:0] req_in1, req_in2;
  logic [N_REQ-1:0]    req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [31:0]         rsp_data, f_in1_data, f_in2_data, f_out_data;
  logic [3:0]          f_ope_data;
  logic                f_in_vld, f_in_rdy, f_out_vld, f_out_rdy, busy, protocol_err;

  always #5 clk = ~clk;

  fpu_arbiter #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req_ope(req_ope), .req_in1(req_in1), .req_in2(req_in2),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .f_ope_data(f_ope_data), .f_in1_data(f_in1_data), .f_in2_data(f_in2_data),
    .f_in_vld(f_in_vld), .f_in_rdy(f_in_rdy),
    .f_out_data(f_out_data), .f_out_vld(f_out_vld), .f_out_rdy(f_out_rdy),
    .busy(busy), .protocol_err(protocol_err)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
  } tag_t;

  // Reference model: outstanding ops in accept order, issue stage, last winner, error flag.
  tag_t        m_q[$];
  logic [31:0] fpu_q[$];
  int          m_ptr;
  bit          m_sv, m_err;
  logic [3:0]  m_ope;
  logic [31:0] m_in1, m_in2;

  // Agents.
  bit          pend [N_REQ];
  logic [3:0]  a_ope [N_REQ];
  logic [31:0] a_in1 [N_REQ];
  logic [31:0] a_in2 [N_REQ];
  bit          out_hold, spurious, force_en;
  logic [31:0] force_val;
  int          p_req, p_in_rdy, p_out, p_rsp;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  function automatic bit chance(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Stand-in FPU function; any deterministic mapping works for routing checks.
  function automatic logic [31:0] fpu_fn(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    if (force_en) return force_val;
    return (a * 32'd3) ^ b ^ {o, 28'h0};
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    req_vld    = '0;
    req_ope    = '0;
    req_in1    = '0;
    req_in2    = '0;
    rsp_rdy    = '0;
    f_in_rdy   = 1'b0;
    f_out_vld  = 1'b0;
    f_out_data = '0;
    spurious   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    fpu_q.delete();
    m_ptr    = N_REQ - 1;
    m_sv     = 1'b0;
    m_err    = 1'b0;
    m_ope    = '0;
    m_in1    = '0;
    m_in2    = '0;
    out_hold = 1'b0;
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      if (!pend[i] && chance(p_req)) begin
        pend[i]  = 1'b1;
        a_ope[i] = 4'($urandom);
        a_in1[i] = $urandom;
        a_in2[i] = $urandom;
      end
      req_vld[i]          = pend[i];
      req_ope[4*i +: 4]   = a_ope[i];
      req_in1[32*i +: 32] = a_in1[i];
      req_in2[32*i +: 32] = a_in2[i];
      rsp_rdy[i]          = chance(p_rsp);
    end
    f_in_rdy = chance(p_in_rdy);
    if (!out_hold && fpu_q.size() > 0 && chance(p_out)) out_hold = 1'b1;
    f_out_vld  = out_hold || spurious;
    f_out_data = (fpu_q.size() > 0) ? fpu_q[0] : $urandom;
  endtask

  task automatic model_check();
    int               cnt, win, head;
    bit               can_acc, found, acc, issue, pop, exp_fordy;
    logic [N_REQ-1:0] exp_rdy, exp_rvld;
    cnt     = m_q.size();
    can_acc = (!m_sv || f_in_rdy) && (cnt < MAX_OUT);
    found   = 1'b0;
    win     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % N_REQ;
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    acc       = found && can_acc;
    exp_rdy   = '0;
    exp_rvld  = '0;
    exp_fordy = 1'b0;
    head      = (cnt > 0) ? int'(m_q[0].id) : -1;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc && i == win) exp_rdy[i] = 1'b1;
      if (i == head) begin
        exp_rvld[i] = f_out_vld;
        exp_fordy   = rsp_rdy[i];
      end
    end
    check_eq("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    check_eq("rsp_vld", 32'(rsp_vld), 32'(exp_rvld));
    check_eq("f_out_rdy", 32'(f_out_rdy), 32'(exp_fordy));
    check_eq("f_in_vld", 32'(f_in_vld), 32'(m_sv));
    check_eq("f_ope", 32'(f_ope_data), 32'(m_ope));
    check_eq("f_in1", f_in1_data, m_in1);
    check_eq("f_in2", f_in2_data, m_in2);
    check_eq("busy", 32'(busy), 32'(cnt != 0));
    check_eq("protocol_err", 32'(protocol_err), 32'(m_err));

    pop   = f_out_vld && exp_fordy;
    issue = m_sv && f_in_rdy;
    if (pop) begin
      check_eq("rsp_data", rsp_data, m_q[0].res);
      void'(m_q.pop_front());
      if (fpu_q.size() > 0) void'(fpu_q.pop_front());
      out_hold = 1'b0;
    end
    if (f_out_vld && cnt == 0) m_err = 1'b1;
    if (issue) fpu_q.push_back(fpu_fn(m_ope, m_in1, m_in2));
    if (acc) begin
      m_q.push_back({2'(win), fpu_fn(a_ope[win], a_in1[win], a_in2[win])});
      m_ope     = a_ope[win];
      m_in1     = a_in1[win];
      m_in2     = a_in2[win];
      m_sv      = 1'b1;
      m_ptr     = win;
      pend[win] = 1'b0;
    end else if (issue) begin
      m_sv = 1'b0;
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int pr, input int pi, input int po, input int ps, input int n);
    p_req    = pr;
    p_in_rdy = pi;
    p_out    = po;
    p_rsp    = ps;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    force_en  = 1'b0;
    force_val = '0;
    do_reset();

    // Single op with a known FPU result of 1.0 + 2.0.
    force_en  = 1'b1;
    force_val = 32'h4040_0000;
    pend[0]   = 1'b1;
    a_ope[0]  = 4'h0;
    a_in1[0]  = 32'h3F80_0000;
    a_in2[0]  = 32'h4000_0000;
    run(0, 100, 100, 100, 8);
    force_en = 1'b0;
    check_eq("single_idle", 32'(busy), 32'd0);

    run(100, 100, 100, 100, 40);   // fairness at full rate
    run(100, 30, 50, 70, 300);     // issue backpressure
    run(100, 100, 0, 100, 20);     // FPU silent: fills to MAX_OUT
    run(100, 100, 60, 100, 50);    // pops resume acceptance
    run(80, 60, 70, 20, 300);      // slow consumers: head-of-line blocking
    run(100, 50, 30, 50, 15);
    do_reset();                    // reset with ops in flight
    run(70, 70, 70, 70, 500);
    run(0, 100, 100, 100, 40);
    check_eq("drain_busy", 32'(busy), 32'd0);
    check_eq("drain_queue", 32'(m_q.size()), 32'd0);

    // Spurious FPU response with nothing outstanding; the error must stick.
    do_reset();
    spurious = 1'b1;
    run(0, 100, 100, 100, 1);
    spurious = 1'b0;
    run(0, 100, 100, 100, 5);
    run(60, 80, 80, 80, 100);
    check_eq("err_sticky", 32'(protocol_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
